// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and widths for the memory bus responder
package mem_bus_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_BUSY = 2'd1, R_DONE = 2'd2} resp_state_t;
endpackage

// File: rtl/resp_mem.sv
// resp_mem: word array with one synchronous write port and a combinational read port
module resp_mem
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     ridx,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[widx] <= wdata;
  assign rdata = mem[ridx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-word read/write responder with fixed access latency and fault reporting
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] address_in,
  input  logic [WORD_W-1:0] data_in,
  input  logic              read_req,
  input  logic              write_req,
  output logic [WORD_W-1:0] data_out,
  output logic              bus_full,
  output logic              ack,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);
  resp_state_t state, state_nx;
  logic [3:0] cnt;
  logic rd_q, fault, done_edge, take;
  logic [WORD_W-1:0] addr_q, wdata_q, rdata;
  // DEPTH is a power of two, so any set bit above the index field is out of range
  assign fault = |addr_q[1:0] || |(addr_q[31:2] >> AW);
  assign done_edge = state == R_BUSY && cnt == 4'd0;
  assign take = state == R_IDLE && (read_req || write_req);
  always_comb begin
    state_nx = state == R_IDLE ? (take ? R_BUSY : R_IDLE) :
               state == R_BUSY ? (cnt == 4'd0 ? R_DONE : R_BUSY) : R_IDLE;
    bus_full = state != R_IDLE;
    ack = state == R_DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= R_IDLE;
      cnt <= '0;
      rd_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      data_out <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        rd_q <= read_req;
        addr_q <= address_in;
        wdata_q <= data_in;
        cnt <= 4'(LATENCY - 1);
      end else if (state == R_BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      err <= done_edge && fault;
      if (done_edge && rd_q) data_out <= fault ? '0 : rdata;
    end
  end
  resp_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (done_edge && !rd_q && !fault),
    .widx (addr_q[AW+1:2]),
    .wdata(wdata_q),
    .ridx (addr_q[AW+1:2]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus reset, busy-drop and latency-sweep sequences
module tb_mem_responder;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] addr = '0, din = '0;
  logic rd [3];
  logic wr [3];
  logic [31:0] dout [3];
  logic bf [3];
  logic ackv [3];
  logic errv [3];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH(256), .LATENCY(2)) u0 (.clk(clk), .rst(rst), .address_in(addr), .data_in(din),
    .read_req(rd[0]), .write_req(wr[0]), .data_out(dout[0]), .bus_full(bf[0]), .ack(ackv[0]), .err(errv[0]));
  mem_responder #(.DEPTH(256), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .address_in(addr), .data_in(din),
    .read_req(rd[1]), .write_req(wr[1]), .data_out(dout[1]), .bus_full(bf[1]), .ack(ackv[1]), .err(errv[1]));
  mem_responder #(.DEPTH(256), .LATENCY(15)) u2 (.clk(clk), .rst(rst), .address_in(addr), .data_in(din),
    .read_req(rd[2]), .write_req(wr[2]), .data_out(dout[2]), .bus_full(bf[2]), .ack(ackv[2]), .err(errv[2]));
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, d, exp_q;
    logic        exp_e;
    string       name;
  } vec_t;
  vec_t v [16];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic access(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] dat,
                        output logic [31:0] q, output logic e, output int n, output int busy);
    @(negedge clk);
    addr = a; din = dat; rd[d] = op[0]; wr[d] = op[1];
    @(posedge clk);
    #1 rd[d] = 1'b0; wr[d] = 1'b0;
    n = 0; busy = 0; q = '0; e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bf[d]) busy++;
      if (ackv[d]) begin
        n = i; q = dout[d]; e = errv[d];
        break;
      end
    end
  endtask
  initial begin
    logic [31:0] q;
    logic e;
    int n, busy, acks;
    int t1 [$];
    int t2 [$];
    for (int i = 0; i < 3; i++) begin rd[i] = 1'b0; wr[i] = 1'b0; end
    v[0]  = '{2'd2, 32'h010, 32'h00000000, 32'h0, 1'b0, "wr_10"};
    v[1]  = '{2'd2, 32'h000, 32'h11111111, 32'h0, 1'b0, "wr_00"};
    v[2]  = '{2'd2, 32'h004, 32'h44444444, 32'h0, 1'b0, "wr_04"};
    v[3]  = '{2'd2, 32'h008, 32'h88888888, 32'h0, 1'b0, "wr_08"};
    v[4]  = '{2'd2, 32'h020, 32'hCAFEF00D, 32'h0, 1'b0, "wr_20"};
    v[5]  = '{2'd1, 32'h020, 32'h0, 32'hCAFEF00D, 1'b0, "rd_20"};
    v[6]  = '{2'd3, 32'h004, 32'h00000001, 32'h44444444, 1'b0, "both_04"};
    v[7]  = '{2'd1, 32'h004, 32'h0, 32'h44444444, 1'b0, "rd_04_unchanged"};
    v[8]  = '{2'd1, 32'h3FE, 32'h0, 32'h0, 1'b1, "rd_misaligned"};
    v[9]  = '{2'd2, 32'h400, 32'h00000BAD, 32'h0, 1'b1, "wr_out_of_range"};
    v[10] = '{2'd1, 32'h000, 32'h0, 32'h11111111, 1'b0, "rd_00_unchanged"};
    v[11] = '{2'd2, 32'h3FC, 32'h12345678, 32'h0, 1'b0, "wr_last_word"};
    v[12] = '{2'd1, 32'h3FC, 32'h0, 32'h12345678, 1'b0, "rd_last_word"};
    v[13] = '{2'd1, 32'h400, 32'h0, 32'h0, 1'b1, "rd_out_of_range"};
    v[14] = '{2'd1, 32'h010, 32'h0, 32'h0, 1'b0, "rd_10"};
    v[15] = '{2'd1, 32'h000, 32'h0, 32'h11111111, 1'b0, "rd_00"};
    repeat (2) @(negedge clk);
    chk("reset_bus_full", 32'(bf[0]), 32'h0);
    chk("reset_ack", 32'(ackv[0]), 32'h0);
    chk("reset_err", 32'(errv[0]), 32'h0);
    chk("reset_data_out", dout[0], 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      access(0, v[i].op, v[i].a, v[i].d, q, e, n, busy);
      chk({v[i].name, "_ack_cycle"}, 32'(n), 32'd3);
      chk({v[i].name, "_busy_cycles"}, 32'(busy), 32'd3);
      chk({v[i].name, "_err"}, 32'(e), 32'(v[i].exp_e));
      if (v[i].op[0]) chk({v[i].name, "_data"}, q, v[i].exp_q);
    end
    // write strobe raised while a read is in flight must be ignored
    @(negedge clk);
    addr = 32'h20; rd[0] = 1'b1;
    @(posedge clk);
    #1 rd[0] = 1'b0; wr[0] = 1'b1; addr = 32'h08; din = 32'h0BADBAD0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ackv[0]) begin n = i; break; end
    end
    wr[0] = 1'b0;
    chk("busy_drop_ack", 32'(n), 32'd3);
    access(0, 2'd1, 32'h08, 32'h0, q, e, n, busy);
    chk("busy_drop_mem", q, 32'h88888888);
    // reset in the middle of a write aborts it
    @(negedge clk);
    addr = 32'h10; din = 32'hDEADBEEF; wr[0] = 1'b1;
    @(posedge clk);
    #1 wr[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(bf[0]), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_bus_full", 32'(bf[0]), 32'h0);
    chk("abort_ack", 32'(ackv[0]), 32'h0);
    chk("abort_err", 32'(errv[0]), 32'h0);
    chk("abort_data_out", dout[0], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (5) begin @(negedge clk); if (ackv[0]) acks++; end
    chk("abort_no_ack", 32'(acks), 32'h0);
    access(0, 2'd1, 32'h10, 32'h0, q, e, n, busy);
    chk("abort_not_committed", q, 32'h0);
    // latency sweep
    access(1, 2'd2, 32'h00, 32'h5A5A5A5A, q, e, n, busy);
    chk("lat1_wr_ack_cycle", 32'(n), 32'd2);
    chk("lat1_wr_busy", 32'(busy), 32'd2);
    access(1, 2'd1, 32'h00, 32'h0, q, e, n, busy);
    chk("lat1_rd_ack_cycle", 32'(n), 32'd2);
    chk("lat1_rd_data", q, 32'h5A5A5A5A);
    access(2, 2'd2, 32'h00, 32'hA5A5A5A5, q, e, n, busy);
    chk("lat15_wr_ack_cycle", 32'(n), 32'd16);
    chk("lat15_wr_busy", 32'(busy), 32'd16);
    access(2, 2'd1, 32'h00, 32'h0, q, e, n, busy);
    chk("lat15_rd_data", q, 32'hA5A5A5A5);
    // held strobes are re-accepted as soon as the responder is idle again
    @(negedge clk);
    addr = 32'h00; rd[1] = 1'b1; rd[2] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ackv[1]) t1.push_back(i);
      if (ackv[2]) t2.push_back(i);
    end
    rd[1] = 1'b0; rd[2] = 1'b0;
    chk("lat1_b2b_count_ge3", 32'(t1.size() >= 3), 32'h1);
    chk("lat15_b2b_count_ge3", 32'(t2.size() >= 3), 32'h1);
    if (t1.size() >= 3) begin
      chk("lat1_b2b_first", 32'(t1[0]), 32'd2);
      chk("lat1_b2b_gap1", 32'(t1[1] - t1[0]), 32'd3);
      chk("lat1_b2b_gap2", 32'(t1[2] - t1[1]), 32'd3);
    end
    if (t2.size() >= 3) begin
      chk("lat15_b2b_first", 32'(t2[0]), 32'd16);
      chk("lat15_b2b_gap1", 32'(t2[1] - t2[0]), 32'd17);
      chk("lat15_b2b_gap2", 32'(t2[2] - t2[1]), 32'd17);
    end
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Bus-side responder for the data/instruction memory controller. It accepts single-word read and write requests and services them from an internal word-addressed memory after a fixed, parameterised access latency. While an access is in flight it holds `bus_full` high, then returns read data with a one-cycle `ack`. It sits between the memory controller and the memory, and stands in as the bus manager for simulation and FPGA builds.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, 4..4096.
- `LATENCY`, 2: wait cycles between request capture and completion; 1..15.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `address_in` input 32: byte address of the request.
- `data_in` input 32: write data.
- `read_req` input 1: read request, sampled only in `R_IDLE`.
- `write_req` input 1: write request, sampled only in `R_IDLE`.
- `data_out` output 32: read data. Holds its value until the next read completes.
- `bus_full` output 1: responder busy. Requests are ignored while this is high.
- `ack` output 1: one-cycle completion pulse.
- `err` output 1: qualifies `ack`; the access faulted and was not performed.

## Operation
- **States:** `R_IDLE`, `R_BUSY`, `R_DONE`.
- **`R_IDLE`:**
  - If `read_req` is high, capture the address and op=read, then go to `R_BUSY`.
  - Otherwise, if `write_req` is high, capture the address, data and op=write, then go to `R_BUSY`.
  - If both are high, read wins and the write is dropped.
  - Otherwise stay in `R_IDLE`.
- **`R_BUSY`:**
  - Load the down-counter with `LATENCY-1` on entry.
  - Stay while counter ≠ 0, decrementing each cycle; go to `R_DONE` when it reaches 0.
- **`R_DONE`:** always returns to `R_IDLE` on the next edge.
- **Fault check**, performed on the captured address:
  - fault if `addr[1:0]` ≠ 0 (misaligned), or
  - fault if `addr[31:2]` ≥ `DEPTH` (out of range).
- **Word index:** `addr[$clog2(DEPTH)+1:2]`.
- **Write:** memory is updated on the edge entering `R_DONE`, only if there is no fault.
- **Read:** `data_out` loads `mem[index]` on the edge entering `R_DONE`. On a fault it loads 0.
- **Outputs:**
  - `bus_full` = state ≠ `R_IDLE`.
  - `ack` = state == `R_DONE`.
  - `err` is registered; it is valid only with `ack` and is 0 otherwise.
- **Reset (asynchronous, `rst`=0):**
  - state=`R_IDLE`, counter=0, `data_out`=0, `bus_full`=0, `ack`=0, `err`=0.
  - Memory contents are not reset.
- **Reset mid-access:** the access is aborted.
  - A write not yet at the `R_DONE` edge is not committed.
  - No `ack` is produced.

## Timing
- Request sampled at edge k, in `R_IDLE`.
- `bus_full`=1 from cycle k+1 through cycle k+LATENCY+1.
- `ack` (with valid `data_out` and `err`) during cycle k+LATENCY+1.
- Back in `R_IDLE` at cycle k+LATENCY+2. The earliest next request is sampled at that cycle's ending edge.
- Total occupancy: LATENCY+1 cycles busy per access. Throughput is one access per LATENCY+2 cycles.
- Request strobes need only be high at the sampling edge. A request held high across completion is re-accepted as a new access.
- Write then read of the same word back-to-back returns the new data, because the write has committed at its `R_DONE` edge.

## Structure
- **Package `mem_bus_pkg`:**
  - `resp_state_t`, a 2-bit enum: `R_IDLE`=0, `R_BUSY`=1, `R_DONE`=2.
  - Localparam `WORD_W`=32.
- **Sub-module `resp_mem`:**
  - `DEPTH` x 32 array.
  - Synchronous write port (`we`, `widx`, `wdata`).
  - Combinational read (`ridx` → `rdata`).
  - No reset.
- The top level holds the FSM, counter, capture registers and output registers.

## Test plan
- **Reset:** `rst`=0 mid-`R_BUSY` on a write of 0xDEADBEEF to 0x10 → outputs 0 immediately. A later read of 0x10 does not return 0xDEADBEEF; pre-load 0x10 with 0x0 before the aborted write.
- **Write/read, LATENCY=2:**
  - Write 0xCAFEF00D to 0x20 → `bus_full` high for 3 cycles, `ack`=1 and `err`=0 in the 3rd cycle.
  - Then read 0x20 → `data_out`=0xCAFEF00D with `ack`.
- **Simultaneous strobes:** `read_req`=`write_req`=1 at 0x04 with `data_in`=0x1 → read performed, memory at 0x04 unchanged.
- **Busy drop:** assert `write_req` to 0x08 while `bus_full`=1 → ignored; 0x08 retains its prior value.
- **Faults:**
  - Read 0x3FE (misaligned) → `ack`=1, `err`=1, `data_out`=0.
  - Write to 0x400 with DEPTH=256 → `err`=1, no memory change (verify 0x0 unchanged).
- **Latency sweep:** LATENCY=1 and LATENCY=15 → `ack` at exactly k+2 and k+16 respectively; back-to-back requests accepted at every LATENCY+2 cycles.
